// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types for the physical-register free list.
package rename_pkg;

    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned NUM_AREGS = 32;
    localparam int unsigned TAG_W     = $clog2(NUM_PREGS);
    localparam int unsigned NUM_FREE  = NUM_PREGS - NUM_AREGS;
    localparam int unsigned PTR_W     = $clog2(NUM_FREE);

    typedef logic [TAG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } fl_state_t;

endpackage

// File: rtl/free_list_mem.sv
// Free-tag storage: one synchronous write port, one asynchronous read port, no reset.
module free_list_mem
    import rename_pkg::*;
(
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [TAG_W-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [TAG_W-1:0] rdata_o
);

    preg_t mem_q [NUM_FREE];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list: circular FIFO of free tags refilled by an init sequencer.
module preg_free_list_ctrl
    import rename_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             alloc_req_i,
    output logic             alloc_grant_o,
    output logic [TAG_W-1:0] alloc_preg_o,
    output logic             stall_o,
    input  logic             rel_valid_i,
    input  logic [TAG_W-1:0] rel_preg_i,
    output logic             rel_err_o,
    output logic [TAG_W-1:0] free_count_o,
    output logic             ready_o
);

    fl_state_t state_q, state_d;
    ptr_t      init_idx_q, init_idx_d;
    ptr_t      head_q, head_d;
    ptr_t      tail_q, tail_d;
    preg_t     cnt_q, cnt_d;
    logic      rel_err_q, rel_err_d;

    logic      run;
    logic      rel_ok;
    logic      rel_legal;
    logic      rel_bad;
    logic      mem_we;
    ptr_t      mem_waddr;
    preg_t     mem_wdata;
    preg_t     mem_rdata;

    always_comb begin
        run           = (state_q == FL_RUN);
        alloc_grant_o = run && alloc_req_i && (cnt_q != '0) && !flush_i;
        stall_o       = !run || (alloc_req_i && (cnt_q == '0));
        // A full list can still accept a release when a grant frees a slot this cycle.
        rel_ok        = rel_valid_i && (rel_preg_i != '0)
                        && ((cnt_q != TAG_W'(NUM_FREE)) || alloc_grant_o);
        rel_legal     = run && !flush_i && rel_ok;
        rel_bad       = run && !flush_i && rel_valid_i && !rel_ok;
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        rel_err_d  = rel_bad;
        if (flush_i) begin
            state_d    = FL_INIT;
            init_idx_d = '0;
            head_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
            rel_err_d  = 1'b0;
        end else if (!run) begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == PTR_W'(NUM_FREE - 1)) begin
                state_d = FL_RUN;
                cnt_d   = TAG_W'(NUM_FREE);
                head_d  = '0;
                tail_d  = '0;
            end
        end else begin
            head_d = head_q + PTR_W'(alloc_grant_o);
            tail_d = tail_q + PTR_W'(rel_legal);
            cnt_d  = cnt_q + TAG_W'(rel_legal) - TAG_W'(alloc_grant_o);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FL_INIT;
            init_idx_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            rel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            rel_err_q  <= rel_err_d;
        end
    end

    always_comb begin
        mem_we    = !run || rel_legal;
        mem_waddr = run ? tail_q : init_idx_q;
        mem_wdata = run ? rel_preg_i : (TAG_W'(NUM_AREGS) + TAG_W'(init_idx_q));
    end

    free_list_mem u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (head_q),
        .rdata_o (mem_rdata)
    );

    assign alloc_preg_o = run ? mem_rdata : '0;
    assign rel_err_o    = rel_err_q;
    assign free_count_o = cnt_q;
    assign ready_o      = run;

endmodule

// File: doc/preg_free_list_ctrl.md
Name: preg_free_list_ctrl

Overview:
- Owns the physical-register free pool for the rename stage.
- Hands out one free physical tag per cycle to rename as the new destination mapping.
- Takes back one retired (stale) tag per cycle from the commit stage.
- Implemented as a circular FIFO of free tags, with an init sequencer that refills the FIFO after reset or pipeline flush; produces the rename stall.

Parameters:
- NUM_PREGS, 64, total physical registers; p0 is hardwired zero and never allocated or freed.
- NUM_AREGS, 32, architectural registers; after init, arch i maps to p i, so the free set is NUM_AREGS..NUM_PREGS-1.
- TAG_W, 6, physical tag width, equal to log2(NUM_PREGS).
- NUM_FREE, NUM_PREGS-NUM_AREGS (32), FIFO depth.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  full pipeline flush; the caller resets the RAT in the same cycle.
- alloc_req  in  1  rename needs a destination tag (dr != x0).
- alloc_grant  out  1  tag on alloc_preg is consumed this cycle.
- alloc_preg  out  TAG_W  tag at FIFO head, combinational.
- stall  out  1  rename must hold.
- rel_valid  in  1  commit returns a stale tag.
- rel_preg  in  TAG_W  tag being returned.
- rel_err  out  1  registered one-cycle pulse: illegal release was dropped.
- free_count  out  TAG_W  registered count of free tags, 0..NUM_FREE.
- ready  out  1  init complete (state RUN).

Behaviour:
- Reset (async, rstn=0):
  - state=INIT, init_idx=0, head=0, tail=0, free_count=0, rel_err=0.
  - Outputs: alloc_grant=0, stall=1, ready=0, alloc_preg=0.
- FSM INIT:
  - Each cycle writes mem[init_idx]=NUM_AREGS+init_idx and increments init_idx.
  - After writing index NUM_FREE-1, moves to RUN with free_count=NUM_FREE, head=0, tail=0.
  - INIT lasts exactly NUM_FREE cycles after reset deassertion.
  - During INIT: stall=1, alloc_grant=0, releases dropped silently (rel_err stays 0).
- FSM RUN:
  - stall = alloc_req && free_count==0. ready=1.
  - alloc_grant = alloc_req && free_count!=0.
  - alloc_preg = mem[head] whenever state=RUN (valid only when free_count!=0, else don't-care), 0 otherwise.
  - On grant: head advances at the clock edge. Latency 0: the tag is usable by rename in the same cycle.
  - Release is legal when rel_valid, rel_preg!=0 and free_count<NUM_FREE. It writes mem[tail] at the edge; tail advances.
  - A released tag is not allocatable before the following cycle. There is no same-cycle bypass.
  - free_count next = free_count + legal_release - grant. Grant and release in the same cycle leave it unchanged.
  - free_count==0 with a simultaneous release: the allocation stalls and free_count becomes 1.
  - Illegal release (tag 0, or free_count==NUM_FREE with no concurrent grant): dropped, rel_err=1 next cycle. FIFO state is unchanged.
  - Release while full with a concurrent grant is legal.
- Pointers: log2(NUM_FREE)-bit, wrap naturally from NUM_FREE-1 to 0.
- flush (sampled in any state):
  - Next state INIT, init_idx=0, head=tail=0, free_count=0.
  - A grant or release in the flush cycle is discarded.
  - flush has priority over all other inputs.
- The block never checks for duplicate tags; commit is responsible for freeing each stale tag exactly once.

Decomposition:
- rename_pkg holds:
  - constants NUM_PREGS, NUM_AREGS, TAG_W, NUM_FREE;
  - typedef preg_t (logic [TAG_W-1:0]);
  - enum fl_state_t {FL_INIT, FL_RUN}.
- One sub-module, free_list_mem: NUM_FREE x TAG_W register array with 1 sync write port and 1 async read port. No reset on contents; INIT fills it.
- FSM, pointers, count and error logic stay in the top module.

Test Plan:
- Reset release, idle 32 cycles -> ready rises exactly on cycle 32, free_count=32, alloc_preg=32; stall=1 throughout INIT while alloc_req=1.
- 32 back-to-back alloc_req after init -> tags 32..63 in order, free_count=0; 33rd request gives stall=1, alloc_grant=0.
- Empty list, alloc_req=1 and rel_valid=1 with rel_preg=5 in the same cycle -> stall=1 that cycle; next cycle alloc_preg=5, grant=1, free_count returns to 0.
- Full list:
  - rel_preg=7 alone -> dropped, rel_err pulses 1 for one cycle, free_count stays 32.
  - rel_preg=0 -> same response.
  - rel_preg=7 together with a grant -> accepted, free_count stays 32.
- 40 alloc/release pairs cycling tags -> pointers wrap past 31; FIFO order preserved; free_count constant.
- flush mid-RUN with free_count=10 and a simultaneous alloc -> no grant, state INIT, then after 32 cycles free_count=32 and alloc_preg=32. Repeat with async rstn low mid-INIT -> INIT restarts from index 0.
